// File: rtl/exec_stage_p.sv
// Execution stage: registered ALU result, {P,V,Z,C} flags, output port and DM write data behind a valid/ready handshake.
// Define EXEC_MUL_EN to compile in the W-cycle iterative shift-add multiplier (opcode 10011); otherwise 10011 is a hold op.
module exec_stage_p #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op_dec,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] ans_ex,
  output logic [W-1:0] ans_hi,
  output logic [W-1:0] data_out,
  output logic [W-1:0] DM_data,
  output logic [3:0]   flag_ex,
  output logic         out_valid,
  output logic         busy
);

  localparam int SW = $clog2(W);

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_MOV, K_AND, K_OR, K_XOR, K_NOT,
    K_IN, K_OUT, K_SHL, K_SHR, K_ASR, K_MUL, K_HOLD
  } kind_t;

  kind_t          kind;
  logic           accept;
  logic [W-1:0]   ans_q;
  logic [W-1:0]   dout_q;
  logic [W-1:0]   dm_q;
  logic [3:0]     flag_q;
  logic           ovld_q;

  logic           sub;
  logic [W-1:0]   b_eff;
  logic [W:0]     add_full;
  logic [W-1:0]   low_sum;
  logic [SW-1:0]  shamt;
  logic [W-1:0]   asr_res;
  logic [W-1:0]   alu_res;
  logic           alu_v;
  logic           alu_c;
  logic           alu_wr;
  logic [3:0]     alu_flags;

  // Opcodes with bit 4 clear alias on their low three bits.
  always_comb begin
    kind = K_HOLD;
    if (!op_dec[4]) begin
      case (op_dec[2:0])
        3'b000:  kind = K_ADD;
        3'b001:  kind = K_SUB;
        3'b010:  kind = K_MOV;
        3'b100:  kind = K_AND;
        3'b101:  kind = K_OR;
        3'b110:  kind = K_XOR;
        3'b111:  kind = K_NOT;
        default: kind = K_HOLD;
      endcase
    end else begin
      case (op_dec)
        5'b10110: kind = K_IN;
        5'b10111: kind = K_OUT;
        5'b11001: kind = K_SHL;
        5'b11010: kind = K_SHR;
        5'b11011: kind = K_ASR;
`ifdef EXEC_MUL_EN
        5'b10011: kind = K_MUL;
`endif
        default:  kind = K_HOLD;
      endcase
    end
  end

  assign sub      = (kind == K_SUB);
  assign b_eff    = sub ? ~B : B;
  assign add_full = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  // Carry into the msb, needed for the overflow flag.
  assign low_sum  = {1'b0, A[W-2:0]} + {1'b0, b_eff[W-2:0]} + {{(W-1){1'b0}}, sub};
  assign shamt    = B[SW-1:0];
  assign asr_res  = W'($signed(A) >>> shamt);

  always_comb begin
    alu_res = ans_q;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_wr  = 1'b1;
    case (kind)
      K_ADD, K_SUB: begin
        alu_res = add_full[W-1:0];
        alu_c   = add_full[W];
        alu_v   = low_sum[W-1] ^ add_full[W];
      end
      K_MOV:   alu_res = B;
      K_AND:   alu_res = A & B;
      K_OR:    alu_res = A | B;
      K_XOR:   alu_res = A ^ B;
      K_NOT:   alu_res = ~B;
      K_IN:    alu_res = data_in;
      K_SHL:   alu_res = A << shamt;
      K_SHR:   alu_res = A >> shamt;
      K_ASR:   alu_res = asr_res;
      default: alu_wr  = 1'b0;
    endcase
    alu_flags = {^alu_res, alu_v, (alu_res == '0), alu_c};
  end

`ifdef EXEC_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t         state_q;
  logic [SW:0]    cnt_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   hi_q;
  logic [2*W-1:0] acc_d;
  logic [3:0]     mul_flags;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_flags = {^acc_d[W-1:0], 1'b0, (acc_d == '0), (acc_d[2*W-1:W] != '0)};
  assign in_ready  = reset & (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign ans_hi    = hi_q;
`else
  assign in_ready  = reset;
  assign busy      = 1'b0;
  assign ans_hi    = '0;
`endif

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_q    <= '0;
      dout_q   <= '0;
      dm_q     <= '0;
      flag_q   <= '0;
      ovld_q   <= 1'b0;
`ifdef EXEC_MUL_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
`endif
    end else begin
      ovld_q <= 1'b0;
      if (accept) begin
        dm_q <= B;
`ifdef EXEC_MUL_EN
        if (kind == K_MUL) begin
          mcand_q  <= {{W{1'b0}}, A};
          mplier_q <= B;
          acc_q    <= '0;
          cnt_q    <= (SW+1)'(W);
          state_q  <= S_MUL;
        end else
`endif
        begin
          ovld_q <= 1'b1;
          if (alu_wr) begin
            ans_q  <= alu_res;
            flag_q <= alu_flags;
          end
          if (kind == K_OUT) dout_q <= A;
        end
      end
`ifdef EXEC_MUL_EN
      // One shift-add step per edge; the last step publishes the product.
      if (state_q == S_MUL) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == (SW+1)'(1)) begin
          ans_q   <= acc_d[W-1:0];
          hi_q    <= acc_d[2*W-1:W];
          flag_q  <= mul_flags;
          ovld_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      end
`endif
    end
  end

  assign ans_ex    = ans_q;
  assign data_out  = dout_q;
  assign DM_data   = dm_q;
  assign flag_ex   = flag_q;
  assign out_valid = ovld_q;

endmodule
